mem_access_unit: RTL and testbench
==================================

# mem_access_unit

CPU-side initiator for the word-organised data memory: turns M-stage load/store instructions into word-aligned memory requests with byte enables, and returns sign/zero-extended load data. Checks alignment and address range, raising AdEL/AdES, and stalls the pipeline while a request is outstanding. Sits between the M-stage register and the data memory port (directly or through the bridge); the memory may acknowledge with variable latency.

## Interface
Parameters:
- DM_BASE, 32'h0000_0000, first legal data byte address
- DM_LAST, 32'h0000_2FFF, last legal data byte address (3072 words)

Ports (reset is synchronous, active-high, single clock):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- op_valid  in  1  M stage holds a memory instruction
- op_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- addr  in  32  byte address from ALU
- wdata  in  32  raw rt value
- pc  in  32  instruction PC (carried to mem_pc)
- flush  in  1  M-stage instruction killed by exception/eret
- stall  out  1  hold pipeline (comb)
- rdata  out  32  extended load result (registered)
- rdata_valid  out  1  one-cycle pulse, rdata valid
- exc  out  1  address exception (comb)
- exc_code  out  5  4 = AdEL, 5 = AdES, else 0
- mem_req  out  1  request to memory (registered)
- mem_we  out  1  request is a write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_byteen  out  4  byte lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_pc  out  32  PC of issued request
- mem_ack  in  1  memory completes current request
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- FSM states IDLE, REQ, DONE. Reset -> IDLE; all outputs 0.
- Exception check (comb, IDLE only, op_valid=1): misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0) or addr outside [DM_BASE, DM_LAST] -> exc=1, exc_code 4 for loads, 5 for stores; no request, stall=0, stay IDLE.
- IDLE, op_valid=1, no exception, flush=0: latch op/addr/pc, drive mem_* bus, go REQ; stall=1.
- Byte enables: SW 1111; SH addr[1]=0 -> 0011, =1 -> 1100; SB 0001<<addr[1:0]; loads 1111, mem_we=0.
- Store data: SW wdata; SH {wdata[15:0] x2}; SB {wdata[7:0] x4}.
- REQ: mem_req and bus held stable until mem_ack=1; stall=1. On ack: loads capture selected lane from mem_rdata -> rdata (LH/LB sign-extend, LHU/LBU zero-extend, lane = addr[1:0] / addr[1]); go DONE.
- DONE: rdata_valid=1 (loads only), stall=0, mem_req=0; go IDLE next cycle. rdata holds until next load completes.
- flush in IDLE: nothing issued. flush in REQ: request still held until ack (no partial transaction; store is committed), result discarded, no rdata_valid, go IDLE directly (skip DONE), stall=0 in the ack cycle.
- mem_ack outside REQ ignored.

## Timing
- Load/store minimum latency 3 cycles: N accept (stall=1), N+1 REQ with mem_req=1 and ack=1, N+2 DONE (stall=0, rdata_valid=1).
- Each extra wait cycle of mem_ack adds one stall cycle.
- Exception path: zero cycles, exc valid same cycle as op_valid.
- Reset mid-REQ: mem_req=0 next edge, state IDLE, captured data dropped.
- Back-to-back ops: next op accepted in the cycle after DONE (IDLE).

## Test plan
- Reset: assert reset 2 cycles mid-REQ -> mem_req=0, stall=0, rdata=0, state IDLE next cycle.
- SB addr=0x0000_0013 wdata=0x1234_56AB, ack immediate -> mem_addr=0x10, byteen=1000, mem_wdata=0xABAB_ABAB, stall 1,1,0.
- LH addr=0x0000_0022, mem_rdata=0x8001_7FFF, ack after 3 waits -> rdata=0xFFFF_8001 with rdata_valid pulse; LHU same -> 0x0000_8001; stall high 5 cycles.
- LW addr=0x0000_0006 -> exc=1, exc_code=4, mem_req never asserts; SW addr=0x0000_3000 -> exc_code=5.
- flush while in REQ for LB, ack 2 cycles later -> mem_req held until ack, no rdata_valid, IDLE after ack.
- Back-to-back SW 0x0 then LW 0x0 with ack immediate -> LW returns stored word; second mem_req rises 3 cycles after first.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-organised data memory: alignment/range checks,
// byte-lane request generation, and sign/zero-extended load return.
module mem_access_unit #(
  parameter logic [31:0] DM_BASE = 32'h0000_0000,
  parameter logic [31:0] DM_LAST = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic        killed;
  logic        is_store, misalign, out_of_range, bad, accept, kill_now;
  logic [3:0]  be;
  logic [31:0] wd, ext;
  logic [15:0] half;
  logic [7:0]  bsel;

  assign is_store = (op_type >= OP_SW);

  always_comb begin
    misalign = 1'b0;
    case (op_type)
      OP_LW, OP_SW:         misalign = |addr[1:0];
      OP_LH, OP_LHU, OP_SH: misalign = addr[0];
      default:              misalign = 1'b0;
    endcase
  end

  // Offset compare covers both bounds with one unsigned test.
  assign out_of_range = (addr - DM_BASE) > (DM_LAST - DM_BASE);
  assign bad      = misalign | out_of_range;
  assign exc      = (state == IDLE) && op_valid && bad;
  assign exc_code = exc ? (is_store ? 5'd5 : 5'd4) : 5'd0;
  assign accept   = (state == IDLE) && op_valid && !bad && !flush;
  assign kill_now = killed | flush;
  // A killed request releases the pipeline in its ack cycle instead of via DONE.
  assign stall    = accept | ((state == REQ) && !(mem_ack && kill_now));

  always_comb begin
    be = 4'b1111;
    wd = wdata;
    case (op_type)
      OP_SH: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      default: begin end
    endcase
  end

  assign half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign bsel = mem_rdata[{lane_q, 3'b000} +: 8];

  always_comb begin
    case (op_q)
      OP_LH:   ext = {{16{half[15]}}, half};
      OP_LHU:  ext = {16'h0, half};
      OP_LB:   ext = {{24{bsel[7]}}, bsel};
      OP_LBU:  ext = {24'h0, bsel};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      killed      <= 1'b0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_byteen  <= 4'h0;
      mem_wdata   <= 32'h0;
      mem_pc      <= 32'h0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q       <= op_type;
          lane_q     <= addr[1:0];
          killed     <= 1'b0;
          mem_req    <= 1'b1;
          mem_we     <= is_store;
          mem_addr   <= {addr[31:2], 2'b00};
          mem_byteen <= be;
          mem_wdata  <= wd;
          mem_pc     <= pc;
          state      <= REQ;
        end
        REQ: begin
          if (flush) killed <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            killed  <= 1'b0;
            if (kill_now) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              if (op_q < OP_SW) begin
                rdata       <= ext;
                rdata_valid <= 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vector table, reset/back-to-back sequences and
// randomized ops checked against a word-array memory model with arithmetic lane rules.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] addr, wdata, pc;
  logic        flush;
  logic        stall, rdata_valid, exc;
  logic [31:0] rdata;
  logic [4:0]  exc_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_pc;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type), .addr(addr),
    .wdata(wdata), .pc(pc), .flush(flush), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .exc(exc), .exc_code(exc_code), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_pc(mem_pc), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr, wdata, mword;
    int          waits;
    int          flush_at;  // -2: flush in accept cycle, -1: none, k: REQ cycle k
    logic        exp_exc;
    logic [4:0]  exp_code;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd;
  } vec_t;

  logic [31:0] mem [0:3071];
  int vecs = 0, miscompares = 0;
  int req_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: access size decides alignment, lane mask and replication.
  function automatic vec_t model(input vec_t v);
    int size;
    bit st, sgn;
    logic [31:0] sh, rd;
    st   = (v.op >= 3'd5);
    size = (v.op == 3'd0 || v.op == 3'd5) ? 4 :
           (v.op == 3'd1 || v.op == 3'd2 || v.op == 3'd6) ? 2 : 1;
    v.exp_exc  = ((v.addr % size) != 0) || (v.addr > 32'h2FFF);
    v.exp_code = v.exp_exc ? (st ? 5'd5 : 5'd4) : 5'd0;
    v.exp_be   = st ? 4'(((1 << size) - 1) << (v.addr % 4)) : 4'hF;
    v.exp_wd   = (size == 4) ? v.wdata :
                 (size == 2) ? (v.wdata & 32'hFFFF) * 32'h0001_0001 :
                               (v.wdata & 32'hFF) * 32'h0101_0101;
    sh  = v.mword >> (8 * (v.addr % 4));
    sgn = (v.op == 3'd1 || v.op == 3'd3);
    if (size == 4) rd = v.mword;
    else if (size == 2) begin
      rd = sh & 32'hFFFF;
      if (sgn && rd >= 32'h8000) rd = rd - 32'h1_0000;
    end else begin
      rd = sh & 32'hFF;
      if (sgn && rd >= 32'h80) rd = rd - 32'h100;
    end
    v.exp_rd = rd;
    return v;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic do_op(input vec_t v, input string tag);
    bit st, killed;
    int idx;
    logic [31:0] pcv, w;
    st = (v.op >= 3'd5);
    idx = int'(v.addr[13:2]);
    killed = 0;
    pcv = $urandom;
    op_valid = 1'b1; op_type = v.op; addr = v.addr; wdata = v.wdata; pc = pcv;
    flush = (v.flush_at == -2); mem_ack = 1'b0;
    #1;
    chk({tag, " exc"}, exc, v.exp_exc);
    chk({tag, " exc_code"}, exc_code, v.exp_code);
    chk({tag, " accept stall"}, stall, !v.exp_exc && v.flush_at != -2);
    if (v.exp_exc || v.flush_at == -2) begin
      @(negedge clk); op_valid = 1'b0; flush = 1'b0; #1;
      chk({tag, " no mem_req"}, mem_req, 0);
      chk({tag, " idle stall"}, stall, 0);
      return;
    end
    @(negedge clk);
    req_cyc = cyc;
    chk({tag, " mem_req"}, mem_req, 1);
    chk({tag, " mem_we"}, mem_we, st);
    chk({tag, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
    chk({tag, " mem_byteen"}, mem_byteen, v.exp_be);
    chk({tag, " mem_pc"}, mem_pc, pcv);
    if (st) chk({tag, " mem_wdata"}, mem_wdata, v.exp_wd);
    for (int k = 0; k <= v.waits; k++) begin
      if (k > 0) @(negedge clk);
      flush = (k == v.flush_at);
      if (flush) killed = 1;
      mem_ack = (k == v.waits);
      mem_rdata = mem_ack ? mem[idx] : $urandom;
      #1;
      chk({tag, " req stall"}, stall, !(mem_ack && killed));
      chk({tag, " req held"}, mem_req, 1);
      if (mem_ack && st) begin
        w = mem[idx];
        for (int b = 0; b < 4; b++)
          if (v.exp_be[b]) w[8*b +: 8] = v.exp_wd[8*b +: 8];
        mem[idx] = w;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; flush = 1'b0; op_valid = 1'b0; mem_rdata = $urandom;
    #1;
    chk({tag, " post mem_req"}, mem_req, 0);
    chk({tag, " post stall"}, stall, 0);
    chk({tag, " rdata_valid"}, rdata_valid, !st && !killed);
    if (!st && !killed) chk({tag, " rdata"}, rdata, v.exp_rd);
    if (!killed) begin
      @(negedge clk); #1;
      chk({tag, " rdata_valid drop"}, rdata_valid, 0);
    end
  endtask

  vec_t tbl [15];
  vec_t v;
  int r1, r2;

  initial begin
    tbl[0]  = '{3'd7, 32'h13,   32'h1234_56AB, 32'h0,         0, -1, 1'b0, 5'd0, 4'b1000, 32'hABAB_ABAB, 32'h0};
    tbl[1]  = '{3'd1, 32'h22,   32'h0,         32'h8001_7FFF, 3, -1, 1'b0, 5'd0, 4'hF,    32'h0, 32'hFFFF_8001};
    tbl[2]  = '{3'd2, 32'h22,   32'h0,         32'h8001_7FFF, 3, -1, 1'b0, 5'd0, 4'hF,    32'h0, 32'h0000_8001};
    tbl[3]  = '{3'd0, 32'h6,    32'h0,         32'h0,         0, -1, 1'b1, 5'd4, 4'hF,    32'h0, 32'h0};
    tbl[4]  = '{3'd5, 32'h3000, 32'h0,         32'h0,         0, -1, 1'b1, 5'd5, 4'hF,    32'h0, 32'h0};
    tbl[5]  = '{3'd3, 32'h1,    32'h0,         32'h0000_80F0, 1, -1, 1'b0, 5'd0, 4'hF,    32'h0, 32'hFFFF_FF80};
    tbl[6]  = '{3'd4, 32'h3,    32'h0,         32'hC500_0000, 0, -1, 1'b0, 5'd0, 4'hF,    32'h0, 32'h0000_00C5};
    tbl[7]  = '{3'd6, 32'h2E,   32'hAAAA_1234, 32'h0,         0, -1, 1'b0, 5'd0, 4'b1100, 32'h1234_1234, 32'h0};
    tbl[8]  = '{3'd0, 32'h2FFC, 32'h0,         32'hDEAD_BEEF, 2, -1, 1'b0, 5'd0, 4'hF,    32'h0, 32'hDEAD_BEEF};
    tbl[9]  = '{3'd1, 32'h2FFF, 32'h0,         32'h0,         0, -1, 1'b1, 5'd4, 4'hF,    32'h0, 32'h0};
    tbl[10] = '{3'd7, 32'h2FFF, 32'h0000_00EE, 32'h0,         0, -1, 1'b0, 5'd0, 4'b1000, 32'hEEEE_EEEE, 32'h0};
    tbl[11] = '{3'd3, 32'h40,   32'h0,         32'h1122_3344, 2,  0, 1'b0, 5'd0, 4'hF,    32'h0, 32'h0};
    tbl[12] = '{3'd0, 32'h44,   32'h0,         32'h5566_7788, 1,  1, 1'b0, 5'd0, 4'hF,    32'h0, 32'h0};
    tbl[13] = '{3'd5, 32'h48,   32'h1,         32'h0,         0, -2, 1'b0, 5'd0, 4'hF,    32'h1, 32'h0};
    tbl[14] = '{3'd5, 32'h4,    32'hCAFE_F00D, 32'h0,         0, -1, 1'b0, 5'd0, 4'hF,    32'hCAFE_F00D, 32'h0};

    for (int i = 0; i < 3072; i++) mem[i] = $urandom;
    reset = 1'b1; op_valid = 1'b0; op_type = 3'd0; addr = 32'h0; wdata = 32'h0;
    pc = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset stall", stall, 0);
    chk("reset rdata", rdata, 0);
    chk("reset rdata_valid", rdata_valid, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset exc", exc, 0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].op < 3'd5 && !tbl[i].exp_exc) mem[tbl[i].addr[13:2]] = tbl[i].mword;
      do_op(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset while a load waits for its ack.
    op_valid = 1'b1; op_type = 3'd0; addr = 32'h100; flush = 1'b0; mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("rst seq mem_req", mem_req, 1);
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    chk("rst seq mem_req", mem_req, 0);
    chk("rst seq stall", stall, 0);
    chk("rst seq rdata", rdata, 0);
    chk("rst seq rdata_valid", rdata_valid, 0);
    // Ack with nothing outstanding must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("stray ack mem_req", mem_req, 0);
    chk("stray ack rdata_valid", rdata_valid, 0);
    chk("stray ack rdata", rdata, 0);

    // Back-to-back SW then LW to the same word.
    v = '{3'd5, 32'h0, 32'h5A5A_C3C3, 32'h0, 0, -1, 1'b0, 5'd0, 4'hF, 32'h5A5A_C3C3, 32'h0};
    do_op(v, "b2b sw");
    r1 = req_cyc;
    v = '{3'd0, 32'h0, 32'h0, 32'h0, 0, -1, 1'b0, 5'd0, 4'hF, 32'h0, 32'h5A5A_C3C3};
    do_op(v, "b2b lw");
    r2 = req_cyc;
    chk("b2b req spacing", r2 - r1, 3);

    for (int n = 0; n < 200; n++) begin
      int r;
      v.op = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      v.addr = (r == 0) ? $urandom_range(32'h3000, 32'h3FFF) : $urandom_range(0, 32'h2FFF);
      v.wdata = $urandom;
      v.waits = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      v.flush_at = (r == 0) ? -2 : (r == 1) ? $urandom_range(0, v.waits) : -1;
      v.mword = 32'h0;
      v = model(v);
      if (!v.exp_exc) begin
        v.mword = mem[v.addr[13:2]];
        v = model(v);
      end
      do_op(v, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
